// File: rtl/decode.sv
// Instruction-decode stage: field decode, 32-entry register file, load-use
// hazard detection, jump redirect and the ID/EX pipeline register.
module decode #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          REGBYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      FetchData_IF,
    input  logic [31:0]      Pc_IF,
    input  logic             BranchTaken_EX,
    input  logic             RegWrite_WB,
    input  logic [4:0]       WriteReg_WB,
    input  logic [WIDTH-1:0] WriteData_WB,
    output logic             AnyStall,
    output logic             Jump_ID,
    output logic [31:0]      RedirectPc_ID,
    output logic             Valid_EX,
    output logic             RegWrite_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             Branch_EX,
    output logic [5:0]       Funct_EX,
    output logic [4:0]       Rs_EX,
    output logic [4:0]       Rt_EX,
    output logic [4:0]       DestReg_EX,
    output logic [WIDTH-1:0] RsData_EX,
    output logic [WIDTH-1:0] RtData_EX,
    output logic [WIDTH-1:0] Imm_EX,
    output logic [31:0]      Pc_EX
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
        logic [5:0]       funct;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       dest;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic [31:0]      pc;
    } id_ex_t;

    id_ex_t           id_ex_q, id_ex_d;
    logic [WIDTH-1:0] rf_q [32];

    logic [5:0]       op;
    logic [4:0]       rs, rt, rd;
    logic             dec_reg_write, dec_mem_read, dec_mem_write, dec_branch;
    logic             dec_uses_rt, dec_is_jump, dec_link;
    logic [4:0]       dec_dest;
    logic [WIDTH-1:0] rs_data, rt_data;
    logic [31:0]      pc_plus8;
    logic [3:0]       jump_region;
    logic             any_stall;

    assign op = FetchData_IF[31:26];
    assign rs = FetchData_IF[25:21];
    assign rt = FetchData_IF[20:16];
    assign rd = FetchData_IF[15:11];

    // Control decode from the opcode; unknown opcodes decode as a nop.
    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_uses_rt   = 1'b0;
        dec_is_jump   = 1'b0;
        dec_link      = 1'b0;
        dec_dest      = 5'd0;
        case (op)
            OpRtype: begin
                dec_reg_write = 1'b1;
                dec_uses_rt   = 1'b1;
                dec_dest      = rd;
            end
            OpLw: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_dest      = rt;
            end
            OpSw: begin
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OpBeq: begin
                dec_branch  = 1'b1;
                dec_uses_rt = 1'b1;
            end
            OpAddi: begin
                dec_reg_write = 1'b1;
                dec_dest      = rt;
            end
            OpJ: dec_is_jump = 1'b1;
            OpJal: begin
                dec_is_jump   = 1'b1;
                dec_link      = 1'b1;
                dec_reg_write = 1'b1;
                dec_dest      = 5'd31;
            end
            default: ;
        endcase
    end

    // Register file read ports; r0 is hardwired, optional same-cycle WB forwarding.
    always_comb begin
        rs_data = rf_q[rs];
        rt_data = rf_q[rt];
        if (rs == 5'd0) begin
            rs_data = '0;
        end else if (REGBYPASS && RegWrite_WB && (WriteReg_WB == rs)) begin
            rs_data = WriteData_WB;
        end
        if (rt == 5'd0) begin
            rt_data = '0;
        end else if (REGBYPASS && RegWrite_WB && (WriteReg_WB == rt)) begin
            rt_data = WriteData_WB;
        end
    end

    // Register file write port; writes to r0 are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RegWrite_WB && (WriteReg_WB != 5'd0)) begin
            rf_q[WriteReg_WB] <= WriteData_WB;
        end
    end

    assign pc_plus8 = Pc_IF + 32'd8;
    // Top nibble of Pc_IF+4: only carries when Pc_IF[27:2] is all ones.
    assign jump_region = Pc_IF[31:28] + {3'b000, &Pc_IF[27:2]};
    assign RedirectPc_ID = {jump_region, FetchData_IF[25:0], 2'b00};

    assign any_stall = id_ex_q.mem_read && (id_ex_q.rt != 5'd0) &&
                       ((id_ex_q.rt == rs) || (dec_uses_rt && (id_ex_q.rt == rt))) &&
                       !BranchTaken_EX;
    assign AnyStall  = any_stall && !reset;
    assign Jump_ID   = dec_is_jump && !BranchTaken_EX && !any_stall && !reset;

    // ID/EX next state: bubble on squash or stall, otherwise the decoded instruction.
    always_comb begin
        id_ex_d = '0;
        if (!BranchTaken_EX && !any_stall) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.reg_write = dec_reg_write;
            id_ex_d.mem_read  = dec_mem_read;
            id_ex_d.mem_write = dec_mem_write;
            id_ex_d.branch    = dec_branch;
            id_ex_d.funct     = FetchData_IF[5:0];
            id_ex_d.rs        = rs;
            id_ex_d.rt        = rt;
            id_ex_d.dest      = dec_dest;
            id_ex_d.rs_data   = rs_data;
            id_ex_d.rt_data   = dec_link ? WIDTH'(pc_plus8) : rt_data;
            id_ex_d.imm       = {{(WIDTH - 16){FetchData_IF[15]}}, FetchData_IF[15:0]};
            id_ex_d.pc        = Pc_IF;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign Valid_EX    = id_ex_q.valid;
    assign RegWrite_EX = id_ex_q.reg_write;
    assign MemRead_EX  = id_ex_q.mem_read;
    assign MemWrite_EX = id_ex_q.mem_write;
    assign Branch_EX   = id_ex_q.branch;
    assign Funct_EX    = id_ex_q.funct;
    assign Rs_EX       = id_ex_q.rs;
    assign Rt_EX       = id_ex_q.rt;
    assign DestReg_EX  = id_ex_q.dest;
    assign RsData_EX   = id_ex_q.rs_data;
    assign RtData_EX   = id_ex_q.rt_data;
    assign Imm_EX      = id_ex_q.imm;
    assign Pc_EX       = id_ex_q.pc;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus a randomized run
// checked against a behavioural model of the stage.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] FetchData_IF, Pc_IF, WriteData_WB;
    logic        BranchTaken_EX, RegWrite_WB;
    logic [4:0]  WriteReg_WB;

    logic        AnyStall, Jump_ID, Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, Branch_EX;
    logic [31:0] RedirectPc_ID, RsData_EX, RtData_EX, Imm_EX, Pc_EX;
    logic [5:0]  Funct_EX;
    logic [4:0]  Rs_EX, Rt_EX, DestReg_EX;

    logic        nb_AnyStall, nb_Jump_ID, nb_Valid_EX, nb_RegWrite_EX, nb_MemRead_EX;
    logic        nb_MemWrite_EX, nb_Branch_EX;
    logic [31:0] nb_RedirectPc_ID, nb_RsData_EX, nb_RtData_EX, nb_Imm_EX, nb_Pc_EX;
    logic [5:0]  nb_Funct_EX;
    logic [4:0]  nb_Rs_EX, nb_Rt_EX, nb_DestReg_EX;

    always #5 clk = ~clk;

    decode #(.WIDTH(32), .REGBYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .FetchData_IF(FetchData_IF), .Pc_IF(Pc_IF),
        .BranchTaken_EX(BranchTaken_EX), .RegWrite_WB(RegWrite_WB),
        .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
        .AnyStall(AnyStall), .Jump_ID(Jump_ID), .RedirectPc_ID(RedirectPc_ID),
        .Valid_EX(Valid_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX), .Funct_EX(Funct_EX),
        .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .DestReg_EX(DestReg_EX), .RsData_EX(RsData_EX),
        .RtData_EX(RtData_EX), .Imm_EX(Imm_EX), .Pc_EX(Pc_EX)
    );

    decode #(.WIDTH(32), .REGBYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .FetchData_IF(FetchData_IF), .Pc_IF(Pc_IF),
        .BranchTaken_EX(BranchTaken_EX), .RegWrite_WB(RegWrite_WB),
        .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
        .AnyStall(nb_AnyStall), .Jump_ID(nb_Jump_ID), .RedirectPc_ID(nb_RedirectPc_ID),
        .Valid_EX(nb_Valid_EX), .RegWrite_EX(nb_RegWrite_EX), .MemRead_EX(nb_MemRead_EX),
        .MemWrite_EX(nb_MemWrite_EX), .Branch_EX(nb_Branch_EX), .Funct_EX(nb_Funct_EX),
        .Rs_EX(nb_Rs_EX), .Rt_EX(nb_Rt_EX), .DestReg_EX(nb_DestReg_EX),
        .RsData_EX(nb_RsData_EX), .RtData_EX(nb_RtData_EX), .Imm_EX(nb_Imm_EX),
        .Pc_EX(nb_Pc_EX)
    );

    typedef struct packed {
        bit        valid, rw, mr, mw, br;
        bit [5:0]  funct;
        bit [4:0]  rs, rt, dest;
        bit [31:0] rsd, rtd, imm, pc;
    } ex_t;

    localparam bit [31:0] Nop = 32'hFC00_0000;  // opcode 0x3F: not a known instruction

    int        n_checks = 0;
    int        n_err = 0;
    ex_t       m_ex, m_next;
    bit [31:0] m_rf [32];
    bit        e_stall, e_jump;
    bit [31:0] e_redir;

    function automatic bit [31:0] rtype(input bit [4:0] s, input bit [4:0] t, input bit [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic bit [31:0] itype(input bit [5:0] o, input bit [4:0] s, input bit [4:0] t,
                                        input bit [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic ex_t dut_ex();
        return {Valid_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, Branch_EX, Funct_EX, Rs_EX,
                Rt_EX, DestReg_EX, RsData_EX, RtData_EX, Imm_EX, Pc_EX};
    endfunction

    function automatic bit [31:0] m_read(input bit [4:0] r);
        if (r == 0) return 32'd0;
        if (RegWrite_WB && WriteReg_WB == r) return WriteData_WB;
        return m_rf[r];
    endfunction

    // Behavioural prediction of this cycle's combinational outputs and next EX content.
    task automatic predict();
        bit [31:0] ins = FetchData_IF;
        bit [5:0]  op = ins[31:26];
        bit [4:0]  s = ins[25:21], t = ins[20:16], d = ins[15:11];
        bit is_r = op == 6'h00, is_lw = op == 6'h23, is_sw = op == 6'h2B;
        bit is_beq = op == 6'h04, is_addi = op == 6'h08, is_j = op == 6'h02;
        bit is_jal = op == 6'h03;
        bit uses_t = is_r || is_sw || is_beq;
        e_stall = m_ex.mr && m_ex.rt != 0 && (m_ex.rt == s || (uses_t && m_ex.rt == t))
                  && !BranchTaken_EX;
        e_jump  = (is_j || is_jal) && !BranchTaken_EX && !e_stall;
        e_redir = ((Pc_IF + 32'd4) & 32'hF000_0000) | {4'b0, ins[25:0], 2'b00};
        m_next  = '0;
        if (!BranchTaken_EX && !e_stall) begin
            m_next.valid = 1;
            m_next.rw    = is_r || is_lw || is_addi || is_jal;
            m_next.mr    = is_lw;
            m_next.mw    = is_sw;
            m_next.br    = is_beq;
            m_next.funct = ins[5:0];
            m_next.rs    = s;
            m_next.rt    = t;
            m_next.dest  = is_r ? d : is_jal ? 5'd31 : (is_lw || is_addi) ? t : 5'd0;
            m_next.rsd   = m_read(s);
            m_next.rtd   = is_jal ? Pc_IF + 32'd8 : m_read(t);
            m_next.imm   = 32'($signed(ins[15:0]));
            m_next.pc    = Pc_IF;
        end
    endtask

    task automatic drive(input bit [31:0] ins, input bit [31:0] pc, input bit bt, input bit we,
                         input bit [4:0] wr, input bit [31:0] wd);
        FetchData_IF = ins; Pc_IF = pc; BranchTaken_EX = bt;
        RegWrite_WB = we; WriteReg_WB = wr; WriteData_WB = wd;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        m_ex = m_next;
        if (RegWrite_WB && WriteReg_WB != 0) m_rf[WriteReg_WB] = WriteData_WB;
        #1;
    endtask

    task automatic model_reset();
        m_ex = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
    endtask

    task automatic test_reset();
        drive(32'h0800_0040, 32'h1000, 0, 0, 0, 0);
        n_checks++;
        if (Jump_ID !== 1'b0) begin
            n_err++; $display("FAIL reset_jump: got %b want 0", Jump_ID);
        end
        n_checks++;
        if (dut_ex() !== ex_t'(0)) begin
            n_err++; $display("FAIL reset_idex: got %h want 0", dut_ex());
        end
        FetchData_IF = Nop;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_r0();
        drive(Nop, 32'h0, 0, 1, 5'd5, 32'h1234); tick();
        drive(Nop, 32'h4, 0, 1, 5'd0, 32'hFFFF); tick();
        drive(rtype(5, 0, 7), 32'h8, 0, 0, 0, 0); tick();
        n_checks++;
        if (RsData_EX !== 32'h1234) begin
            n_err++; $display("FAIL r0_rsdata: got %h want 00001234", RsData_EX);
        end
        n_checks++;
        if (RtData_EX !== 32'h0) begin
            n_err++; $display("FAIL r0_rtdata: got %h want 0", RtData_EX);
        end
        n_checks++;
        if (DestReg_EX !== 5'd7 || RegWrite_EX !== 1'b1) begin
            n_err++; $display("FAIL r0_dest: got %0d/%b want 7/1", DestReg_EX, RegWrite_EX);
        end
    endtask

    task automatic test_bypass();
        bit [31:0] old_val;
        drive(Nop, 32'hC, 0, 1, 5'd3, 32'h1111); tick();
        old_val = m_rf[3];
        drive(rtype(3, 0, 8), 32'h10, 0, 1, 5'd3, 32'hCAFE); tick();
        n_checks++;
        if (RsData_EX !== 32'hCAFE) begin
            n_err++; $display("FAIL bypass_on: got %h want 0000cafe", RsData_EX);
        end
        n_checks++;
        if (nb_RsData_EX !== old_val) begin
            n_err++; $display("FAIL bypass_off: got %h want %h", nb_RsData_EX, old_val);
        end
    endtask

    task automatic test_load_use();
        drive(itype(6'h23, 1, 4, 0), 32'h20, 0, 0, 0, 0); tick();
        drive(rtype(4, 2, 6), 32'h24, 0, 0, 0, 0);
        n_checks++;
        if (AnyStall !== 1'b1) begin
            n_err++; $display("FAIL lu_stall: got %b want 1", AnyStall);
        end
        tick();
        n_checks++;
        if (Valid_EX !== 1'b0) begin
            n_err++; $display("FAIL lu_bubble: got %b want 0", Valid_EX);
        end
        drive(rtype(4, 2, 6), 32'h24, 0, 0, 0, 0);
        n_checks++;
        if (AnyStall !== 1'b0) begin
            n_err++; $display("FAIL lu_one_cycle: got %b want 0", AnyStall);
        end
        tick();
        n_checks++;
        if (Valid_EX !== 1'b1 || DestReg_EX !== 5'd6 || Pc_EX !== 32'h24) begin
            n_err++; $display("FAIL lu_reissue: got v=%b d=%0d pc=%h want 1/6/24",
                              Valid_EX, DestReg_EX, Pc_EX);
        end
        drive(itype(6'h23, 1, 0, 0), 32'h28, 0, 0, 0, 0); tick();
        drive(rtype(0, 0, 6), 32'h2C, 0, 0, 0, 0);
        n_checks++;
        if (AnyStall !== 1'b0) begin
            n_err++; $display("FAIL lu_r0: got %b want 0", AnyStall);
        end
        tick();
    endtask

    task automatic test_jump();
        drive(32'h0800_0040, 32'h1000, 0, 0, 0, 0);
        n_checks++;
        if (Jump_ID !== 1'b1 || RedirectPc_ID !== 32'h100) begin
            n_err++; $display("FAIL j_redirect: got %b/%h want 1/00000100", Jump_ID, RedirectPc_ID);
        end
        tick();
        drive(32'h0800_0040, 32'h1FFF_FFFC, 0, 0, 0, 0);
        n_checks++;
        if (RedirectPc_ID !== 32'h2000_0100) begin
            n_err++; $display("FAIL j_region: got %h want 20000100", RedirectPc_ID);
        end
        tick();
        drive(32'h0C00_0040, 32'h1000, 0, 0, 0, 0);
        n_checks++;
        if (Jump_ID !== 1'b1) begin
            n_err++; $display("FAIL jal_jump: got %b want 1", Jump_ID);
        end
        tick();
        n_checks++;
        if (DestReg_EX !== 5'd31 || RtData_EX !== 32'h1008 || RegWrite_EX !== 1'b1) begin
            n_err++; $display("FAIL jal_link: got %0d/%h/%b want 31/00001008/1",
                              DestReg_EX, RtData_EX, RegWrite_EX);
        end
    endtask

    task automatic test_flush();
        drive(itype(6'h23, 1, 4, 0), 32'h40, 0, 0, 0, 0); tick();
        drive({6'h02, 5'd4, 21'h40}, 32'h44, 0, 0, 0, 0);
        n_checks++;
        if (AnyStall !== 1'b1 || Jump_ID !== 1'b0) begin
            n_err++; $display("FAIL stall_jump: got %b/%b want 1/0", AnyStall, Jump_ID);
        end
        drive({6'h02, 5'd4, 21'h40}, 32'h44, 1, 0, 0, 0);
        n_checks++;
        if (AnyStall !== 1'b0 || Jump_ID !== 1'b0) begin
            n_err++; $display("FAIL flush_comb: got %b/%b want 0/0", AnyStall, Jump_ID);
        end
        tick();
        n_checks++;
        if (dut_ex() !== ex_t'(0)) begin
            n_err++; $display("FAIL flush_bubble: got %h want 0", dut_ex());
        end
    endtask

    task automatic test_reset_mid();
        drive(itype(6'h23, 1, 4, 0), 32'h50, 0, 0, 0, 0); tick();
        drive(rtype(4, 2, 6), 32'h54, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (AnyStall !== 1'b0 || Jump_ID !== 1'b0 || dut_ex() !== ex_t'(0)) begin
            n_err++; $display("FAIL reset_async: got %b/%b/%h want 0/0/0",
                              AnyStall, Jump_ID, dut_ex());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        drive(rtype(5, 3, 7), 32'h58, 0, 0, 0, 0); tick();
        n_checks++;
        if (RsData_EX !== 32'h0 || RtData_EX !== 32'h0 || Valid_EX !== 1'b1) begin
            n_err++; $display("FAIL reset_regfile: got %h/%h/%b want 0/0/1",
                              RsData_EX, RtData_EX, Valid_EX);
        end
    endtask

    task automatic test_random();
        bit [5:0]  ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03, 6'h3F, 6'h11};
        bit [31:0] ins = Nop;
        bit [31:0] pc = 32'h400;
        bit        stalled = 0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                ins = {ops[$urandom_range(8)], 5'($urandom_range(7)), 5'($urandom_range(7)),
                       5'($urandom_range(7)), 11'($urandom)};
                pc = pc + 32'd4;
            end
            drive(ins, pc, $urandom_range(7) == 0, 1'($urandom), 5'($urandom_range(7)),
                  $urandom);
            n_checks++;
            if (AnyStall !== e_stall || Jump_ID !== e_jump || RedirectPc_ID !== e_redir) begin
                n_err++; $display("FAIL rand_comb[%0d]: got %b/%b/%h want %b/%b/%h", i,
                                  AnyStall, Jump_ID, RedirectPc_ID, e_stall, e_jump, e_redir);
            end
            stalled = e_stall;
            tick();
            n_checks++;
            if (dut_ex() !== m_ex) begin
                n_err++; $display("FAIL rand_idex[%0d]: got %h want %h", i, dut_ex(), m_ex);
            end
        end
    endtask

    initial begin
        FetchData_IF = Nop; Pc_IF = 0; BranchTaken_EX = 0;
        RegWrite_WB = 0; WriteReg_WB = 0; WriteData_WB = 0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_r0();
        test_bypass();
        test_load_use();
        test_jump();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
